// File: rtl/uc_pkg.sv
// Shared types and constants for the microc sequencer.
// The retire counter is built only when UC_RETIRE_CNT_EN is defined.
package uc_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] ALU_MASK = 6'b100000;
    localparam logic [3:0] OP_LI    = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b1001;
    localparam logic [3:0] OP_JZ    = 4'b1010;
    localparam logic [3:0] OP_JNZ   = 4'b1011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef struct packed {
        logic       instr_req;
        logic       pc_en;
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = 10'b1010000000;
    localparam ctrl_t CTRL_HALT  = 10'b0000000001;
    localparam ctrl_t CTRL_NOP   = 10'b0110000000;

    function automatic logic is_alu(input logic [5:0] op);
        return (op & ALU_MASK) == 6'b000000;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// EXEC-cycle decode: latched opcode plus zero flag to control word.
// Purely combinational; the top selects it only while in EXEC.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic       i_zero,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NOP;
        unique case (1'b1)
            is_alu(i_op): begin
                o_ctrl.we     = 1'b1;
                o_ctrl.wez    = 1'b1;
                o_ctrl.alu_op = i_op[4:2];
            end
            (i_op == OP_HALT): begin
                o_ctrl.pc_en = 1'b0;
                o_ctrl.s_inc = 1'b0;
            end
            (i_op[5:2] == OP_LI): begin
                o_ctrl.s_inm = 1'b1;
                o_ctrl.we    = 1'b1;
            end
            (i_op[5:2] == OP_J): begin
                o_ctrl.s_inc = 1'b0;
            end
            // s_inc low selects the jump target
            (i_op[5:2] == OP_JZ): begin
                o_ctrl.s_inc = ~i_zero;
            end
            (i_op[5:2] == OP_JNZ): begin
                o_ctrl.s_inc = i_zero;
            end
            default: begin
                o_ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/uc_seq.sv
// Fetch/exec sequencer for the microc core; two cycles per instruction.
// Define UC_RETIRE_CNT_EN to add the 16-bit retired counter output.
module uc_seq
    import uc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        instr_valid,
    output logic        instr_req,
    output logic        pc_en,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we,
    output logic        wez,
    output logic [2:0]  AluOP,
    output logic        halted
`ifdef UC_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    ctrl_t      w_dec;
    ctrl_t      w_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= 6'b000000;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && instr_valid)
                r_op <= Opcode;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (instr_valid) w_next = S_EXEC;
            S_EXEC:  w_next = (r_op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    uc_decode u_decode (
        .i_op   (r_op),
        .i_zero (zero),
        .o_ctrl (w_dec)
    );

    always_comb begin
        w_out = CTRL_FETCH;
        case (r_state)
            S_EXEC:  w_out = w_dec;
            S_HALT:  w_out = CTRL_HALT;
            default: w_out = CTRL_FETCH;
        endcase
    end

    assign instr_req = w_out.instr_req;
    assign pc_en     = w_out.pc_en;
    assign s_inc     = w_out.s_inc;
    assign s_inm     = w_out.s_inm;
    assign we        = w_out.we;
    assign wez       = w_out.wez;
    assign AluOP     = w_out.alu_op;
    assign halted    = w_out.halted;

`ifdef UC_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retired <= 16'd0;
        else if (r_state == S_EXEC)
            r_retired <= r_retired + 16'd1;
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Randomized self-checking bench for uc_seq against a rule-level model.
module tb_uc_seq;

    logic        clk;
    logic        reset;
    logic [5:0]  Opcode;
    logic        zero;
    logic        instr_valid;
    logic        instr_req;
    logic        pc_en;
    logic        s_inc;
    logic        s_inm;
    logic        we;
    logic        wez;
    logic [2:0]  AluOP;
    logic        halted;
`ifdef UC_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int n_vec;
    int n_err;
    int exp_ret;

    uc_seq dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .zero        (zero),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .pc_en       (pc_en),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .we          (we),
        .wez         (wez),
        .AluOP       (AluOP),
        .halted      (halted)
`ifdef UC_RETIRE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {instr_req,pc_en,s_inc,s_inm,we,wez,AluOP,halted}
    localparam logic [9:0] V_FETCH = 10'b1010000000;
    localparam logic [9:0] V_HALT  = 10'b0000000001;
    localparam logic [9:0] M_ALL   = 10'b1111111111;
    localparam logic [9:0] M_NOALU = 10'b1110110001;

    function automatic logic [9:0] obs();
        return {instr_req, pc_en, s_inc, s_inm, we, wez, AluOP, halted};
    endfunction

    // Expected EXEC outputs straight from the opcode table.
    function automatic logic [9:0] exp_exec(input logic [5:0] op,
                                            input logic z);
        logic [3:0] top;
        top = op[5:2];
        if (!op[5])
            return {6'b011011, op[4:2], 1'b0};
        if (top == 4'd8)  return 10'b0111100000;
        if (top == 4'd9)  return 10'b0100000000;
        if (top == 4'd10) return {2'b01, ~z, 7'b0000000};
        if (top == 4'd11) return {2'b01, z, 7'b0000000};
        return 10'b0110000000;
    endfunction

    function automatic logic [9:0] exp_mask(input logic [5:0] op);
        if (!op[5] || op[5:2] == 4'd8) return M_ALL;
        return M_NOALU;
    endfunction

    task automatic chk(input string name, input logic [9:0] got,
                       input logic [9:0] exp, input logic [9:0] m);
        n_vec++;
        if ((got & m) !== (exp & m)) begin
            n_err++;
            $display("FAIL %s: got %b want %b (mask %b) t=%0t",
                     name, got, exp, m, $time);
        end
    endtask

    task automatic chk_ret(input string name);
`ifdef UC_RETIRE_CNT_EN
        n_vec++;
        if (retired !== 16'(exp_ret)) begin
            n_err++;
            $display("FAIL %s retired: got %0d want %0d",
                     name, retired, exp_ret);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // Enter at posedge+1 in FETCH; leave at posedge+1 after EXEC.
    task automatic run_instr(input logic [5:0] op, input logic z,
                             input int gap, input string name);
        for (int i = 0; i < gap; i++) begin
            instr_valid = 1'b0;
            Opcode = 6'($urandom);
            zero = 1'($urandom);
            @(posedge clk); #1;
            chk({name, "_wait"}, obs(), V_FETCH, M_ALL);
        end
        Opcode = op;
        instr_valid = 1'b1;
        zero = 1'($urandom);
        @(posedge clk); #1;
        instr_valid = 1'($urandom);
        Opcode = 6'($urandom);
        zero = z;
        #1;
        if (op == 6'h3f)
            chk({name, "_exec"}, obs(), 10'b0000000000, 10'b1100100001);
        else
            chk({name, "_exec"}, obs(), exp_exec(op, z), exp_mask(op));
        exp_ret++;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        #1;
        chk({name, "_after"}, obs(),
            (op == 6'h3f) ? V_HALT : V_FETCH, M_ALL);
        chk_ret(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        Opcode = 6'h00;
        zero = 1'b0;
        #3;
        chk("reset_out", obs(), V_FETCH, M_ALL);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ret = 0;
        chk_ret("reset");
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b0;
            Opcode = 6'($urandom);
            @(posedge clk); #1;
            chk("idle_fetch", obs(), V_FETCH, M_ALL);
        end
    endtask

    task automatic test_li();
        run_instr(6'b100000, 1'b0, 0, "li");
    endtask

    task automatic test_add();
        run_instr(6'b001000, 1'b1, 1, "add");
    endtask

    task automatic test_jz();
        run_instr(6'b101000, 1'b1, 0, "jz_taken");
        run_instr(6'b101000, 1'b0, 0, "jz_fall");
        run_instr(6'b101100, 1'b0, 2, "jnz_taken");
        run_instr(6'b101100, 1'b1, 0, "jnz_fall");
        run_instr(6'b100100, 1'b1, 0, "j");
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 6'($urandom);
            if (op == 6'h3f) op = 6'h3e;
            run_instr(op, 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            run_instr(6'($urandom_range(0, 31)), 1'($urandom), 0, "b2b");
    endtask

    task automatic test_halt();
        run_instr(6'h3f, 1'b0, 0, "halt");
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1'b1;
            Opcode = 6'($urandom);
            @(posedge clk); #1;
            chk("halt_hold", obs(), V_HALT, M_ALL);
        end
        chk_ret("halt_hold");
        reset = 1'b1;
        instr_valid = 1'b0;
        #1;
        chk("halt_reset", obs(), V_FETCH, M_ALL);
        exp_ret = 0;
        chk_ret("halt_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("halt_exit", obs(), V_FETCH, M_ALL);
        run_instr(6'b100000, 1'b0, 0, "post_halt_li");
    endtask

    task automatic test_abort();
        Opcode = 6'b001000;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        #1;
        chk("abort_pre", obs(), exp_exec(6'b001000, 1'b0), M_ALL);
        reset = 1'b1;
        #1;
        chk("abort_now", obs(), V_FETCH, M_ALL);
        exp_ret = 0;
        @(posedge clk); #1;
        chk("abort_edge", obs(), V_FETCH, M_ALL);
        chk_ret("abort");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", obs(), V_FETCH, M_ALL);
        chk_ret("abort_idle");
        run_instr(6'b000100, 1'b0, 0, "post_abort_alu");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_ret = 0;
        test_reset();
        test_li();
        test_add();
        test_jz();
        test_back_to_back();
        test_random();
        test_abort();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
